// File: rtl/slave_arbiter.sv
// Two-master, one-slave round-robin arbiter with per-grant timeout.
// A grant ends on slave ack, on the owner dropping its request, or on timeout.
module slave_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_m0,
  input  logic        req_m1,
  input  logic [31:0] addr_m0,
  input  logic [31:0] addr_m1,
  input  logic [31:0] wdata_m0,
  input  logic [31:0] wdata_m1,
  input  logic        cmd_m0,
  input  logic        cmd_m1,
  input  logic        ack_from_slave,
  input  logic [31:0] rdata_from_slave,
  output logic        connect_approved_m0,
  output logic        connect_approved_m1,
  output logic        ack_to_m0,
  output logic        ack_to_m1,
  output logic [31:0] rdata_to_m0,
  output logic [31:0] rdata_to_m1,
  output logic        req_to_slave,
  output logic [31:0] addr_to_slave,
  output logic [31:0] wdata_to_slave,
  output logic        cmd_to_slave,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic        app0_q, app0_d;
  logic        app1_q, app1_d;
  logic        own_req;
  logic        active;

  assign own_req = owner_q ? req_m1 : req_m0;

  // Next-state logic: ack beats abort, abort beats timeout.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_m0 && req_m1) begin
          state_d = GRANT;
          owner_d = ~last_q;
          cnt_d   = 8'd0;
        end else if (req_m0) begin
          state_d = GRANT;
          owner_d = 1'b0;
          cnt_d   = 8'd0;
        end else if (req_m1) begin
          state_d = GRANT;
          owner_d = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (ack_from_slave || !own_req) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (cnt_q == TMO_LAST) begin
          state_d = IDLE;
          last_d  = owner_q;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    app0_d = (state_d == GRANT) && !owner_d;
    app1_d = (state_d == GRANT) && owner_d;
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
      app0_q  <= 1'b0;
      app1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      app0_q  <= app0_d;
      app1_q  <= app1_d;
    end
  end

  // Routing is gated by rst_n so an in-flight ack never leaks during reset.
  assign active = rst_n && (state_q == GRANT);

  always_comb begin
    req_to_slave   = 1'b0;
    addr_to_slave  = 32'h0;
    wdata_to_slave = 32'h0;
    cmd_to_slave   = 1'b0;
    ack_to_m0      = 1'b0;
    ack_to_m1      = 1'b0;
    rdata_to_m0    = 32'h0;
    rdata_to_m1    = 32'h0;
    if (active) begin
      req_to_slave   = own_req;
      addr_to_slave  = owner_q ? addr_m1 : addr_m0;
      wdata_to_slave = owner_q ? wdata_m1 : wdata_m0;
      cmd_to_slave   = owner_q ? cmd_m1 : cmd_m0;
      if (owner_q) begin
        ack_to_m1   = ack_from_slave;
        rdata_to_m1 = rdata_from_slave;
      end else begin
        ack_to_m0   = ack_from_slave;
        rdata_to_m0 = rdata_from_slave;
      end
    end else begin
      req_to_slave = 1'b0;
    end
  end

  assign connect_approved_m0 = app0_q;
  assign connect_approved_m1 = app1_q;
  assign timeout_err         = tmo_q;

endmodule

// File: tb/tb_slave_arbiter.sv
// Scoreboard bench for slave_arbiter (TIMEOUT=4): stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_slave_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, req_m0, req_m1, cmd_m0, cmd_m1, ack_from_slave;
  logic [31:0] addr_m0, addr_m1, wdata_m0, wdata_m1, rdata_from_slave;
  logic        connect_approved_m0, connect_approved_m1, ack_to_m0, ack_to_m1;
  logic [31:0] rdata_to_m0, rdata_to_m1, addr_to_slave, wdata_to_slave;
  logic        req_to_slave, cmd_to_slave, timeout_err;

  typedef struct {
    string       name;
    logic        ap0, ap1, ack0, ack1, rqs, cms, tmo;
    logic [31:0] rd0, rd1, ads, wds;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  slave_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_m0(req_m0), .req_m1(req_m1),
    .addr_m0(addr_m0), .addr_m1(addr_m1),
    .wdata_m0(wdata_m0), .wdata_m1(wdata_m1),
    .cmd_m0(cmd_m0), .cmd_m1(cmd_m1),
    .ack_from_slave(ack_from_slave), .rdata_from_slave(rdata_from_slave),
    .connect_approved_m0(connect_approved_m0), .connect_approved_m1(connect_approved_m1),
    .ack_to_m0(ack_to_m0), .ack_to_m1(ack_to_m1),
    .rdata_to_m0(rdata_to_m0), .rdata_to_m1(rdata_to_m1),
    .req_to_slave(req_to_slave), .addr_to_slave(addr_to_slave),
    .wdata_to_slave(wdata_to_slave), .cmd_to_slave(cmd_to_slave),
    .timeout_err(timeout_err)
  );

  // Queue the expected outputs for the current cycle (inputs already driven),
  // then advance to just after the next rising edge.
  task automatic step(input string nm, input logic ap0, input logic ap1, input logic tmo);
    exp_t e;
    logic g0, g1;
    g0 = ap0 && rst_n;
    g1 = ap1 && rst_n;
    e.name = nm;
    e.ap0  = ap0;
    e.ap1  = ap1;
    e.tmo  = tmo;
    e.ack0 = g0 && ack_from_slave;
    e.ack1 = g1 && ack_from_slave;
    e.rd0  = g0 ? rdata_from_slave : 32'h0;
    e.rd1  = g1 ? rdata_from_slave : 32'h0;
    e.rqs  = g0 ? req_m0 : (g1 ? req_m1 : 1'b0);
    e.ads  = g0 ? addr_m0 : (g1 ? addr_m1 : 32'h0);
    e.wds  = g0 ? wdata_m0 : (g1 ? wdata_m1 : 32'h0);
    e.cms  = g0 ? cmd_m0 : (g1 ? cmd_m1 : 1'b0);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented output cycle against the scoreboard head.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (connect_approved_m0 !== e.ap0 || connect_approved_m1 !== e.ap1 ||
          ack_to_m0 !== e.ack0 || ack_to_m1 !== e.ack1 ||
          rdata_to_m0 !== e.rd0 || rdata_to_m1 !== e.rd1 ||
          req_to_slave !== e.rqs || addr_to_slave !== e.ads ||
          wdata_to_slave !== e.wds || cmd_to_slave !== e.cms ||
          timeout_err !== e.tmo) begin
        fails++;
        $display("FAIL %s: got ap=%b%b ack=%b%b rd0=%h rd1=%h req=%b addr=%h wd=%h cmd=%b tmo=%b; want ap=%b%b ack=%b%b rd0=%h rd1=%h req=%b addr=%h wd=%h cmd=%b tmo=%b",
                 e.name, connect_approved_m0, connect_approved_m1, ack_to_m0, ack_to_m1,
                 rdata_to_m0, rdata_to_m1, req_to_slave, addr_to_slave, wdata_to_slave,
                 cmd_to_slave, timeout_err, e.ap0, e.ap1, e.ack0, e.ack1, e.rd0, e.rd1,
                 e.rqs, e.ads, e.wds, e.cms, e.tmo);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    req_m0 = 1'b1;
    ack_from_slave = 1'b1;
    rdata_from_slave = 32'hAAAA_5555;
    step("reset_outputs_zero", 1'b0, 1'b0, 1'b0);
    req_m0 = 1'b0;
    ack_from_slave = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_m0 = 1'b0; req_m1 = 1'b0;
    addr_m0 = 32'h0000_0A00; addr_m1 = 32'h0000_0B00;
    wdata_m0 = 32'h1111_0000; wdata_m1 = 32'h2222_0000;
    cmd_m0 = 1'b0; cmd_m1 = 1'b1;
    ack_from_slave = 1'b0; rdata_from_slave = 32'h0;
    do_reset();

    // Single master 0, ack in third grant cycle with read data.
    req_m0 = 1'b1;
    step("m0_idle_c0", 1'b0, 1'b0, 1'b0);
    step("m0_grant_c1", 1'b1, 1'b0, 1'b0);
    step("m0_grant_c2", 1'b1, 1'b0, 1'b0);
    ack_from_slave = 1'b1; rdata_from_slave = 32'hDEAD_BEEF;
    step("m0_ack_c3", 1'b1, 1'b0, 1'b0);
    ack_from_slave = 1'b0; req_m0 = 1'b0;
    step("m0_idle_c4", 1'b0, 1'b0, 1'b0);
    ack_from_slave = 1'b1; rdata_from_slave = 32'hCAFE_F00D;
    step("idle_ignores_ack", 1'b0, 1'b0, 1'b0);
    ack_from_slave = 1'b0;

    // Both requesting after reset: alternate m0, m1, m0, m1 with idle gaps.
    do_reset();
    req_m0 = 1'b1; req_m1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ack_from_slave = 1'b0;
      step($sformatf("rr_idle_%0d", i), 1'b0, 1'b0, 1'b0);
      ack_from_slave = 1'b1;
      rdata_from_slave = 32'h5000_0000 + 32'(i);
      step($sformatf("rr_grant_%0d", i), (i % 2) == 0, (i % 2) == 1, 1'b0);
    end
    ack_from_slave = 1'b0; req_m0 = 1'b0; req_m1 = 1'b0;
    step("rr_done_idle", 1'b0, 1'b0, 1'b0);

    // Master 1 write: mux must follow m1 even with m0 address all ones.
    req_m1 = 1'b1; addr_m1 = 32'h1000_0040; cmd_m1 = 1'b1; wdata_m1 = 32'h0BAD_F00D;
    addr_m0 = 32'hFFFF_FFFF; cmd_m0 = 1'b0;
    step("m1_idle", 1'b0, 1'b0, 1'b0);
    ack_from_slave = 1'b1; rdata_from_slave = 32'h1234_5678;
    step("m1_write_grant", 1'b0, 1'b1, 1'b0);
    ack_from_slave = 1'b0; req_m1 = 1'b0;
    step("m1_done_idle", 1'b0, 1'b0, 1'b0);

    // Timeout: 4 grant cycles, pulse, regrant, then abort on request drop.
    req_m0 = 1'b1;
    step("tmo_idle", 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) step($sformatf("tmo_grant_%0d", i), 1'b1, 1'b0, 1'b0);
    step("tmo_pulse", 1'b0, 1'b0, 1'b1);
    step("tmo_regrant_c1", 1'b1, 1'b0, 1'b0);
    req_m0 = 1'b0;
    step("abort_c2", 1'b1, 1'b0, 1'b0);
    step("abort_idle_c3", 1'b0, 1'b0, 1'b0);

    // Ack coincides with the timeout cycle: ack wins, no error pulse.
    req_m0 = 1'b1;
    step("ackwin_idle", 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) step($sformatf("ackwin_grant_%0d", i), 1'b1, 1'b0, 1'b0);
    ack_from_slave = 1'b1; rdata_from_slave = 32'h7777_0004;
    step("ackwin_ack", 1'b1, 1'b0, 1'b0);
    ack_from_slave = 1'b0; req_m0 = 1'b0;
    step("ackwin_no_tmo", 1'b0, 1'b0, 1'b0);

    // Ack together with owner request drop counts as completion.
    req_m1 = 1'b1;
    step("ackdrop_idle", 1'b0, 1'b0, 1'b0);
    req_m1 = 1'b0; ack_from_slave = 1'b1; rdata_from_slave = 32'h8888_0001;
    step("ackdrop_grant", 1'b0, 1'b1, 1'b0);
    ack_from_slave = 1'b0;
    step("ackdrop_idle2", 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-grant with an ack in flight.
    req_m0 = 1'b1;
    step("rstg_idle", 1'b0, 1'b0, 1'b0);
    step("rstg_grant", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0; ack_from_slave = 1'b1; rdata_from_slave = 32'h9999_0000;
    step("rstg_ack_blocked", 1'b1, 1'b0, 1'b0);
    step("rstg_dropped", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; req_m0 = 1'b0; ack_from_slave = 1'b0;
    step("rstg_idle_after", 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
